// File: rtl/apb_regbank_param.sv
// apb_regbank_param: parametrised APB slave register bank with per-register
// access types, hardware status inputs, pulse outputs, programmable wait
// states and error responses for misaligned, unmapped or reserved accesses.
module apb_regbank_param #(
  parameter int                         ADDR_W      = 10,
  parameter int                         DATA_W      = 32,
  parameter int                         NUM_REGS    = 16,
  parameter int                         WAIT_STATES = 0,
  parameter logic [NUM_REGS*4-1:0]      TYPE_VEC    = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [DATA_W-1:0]          pwdata,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  input  logic [NUM_REGS*DATA_W-1:0] hw_rd_val,
  input  logic [NUM_REGS*DATA_W-1:0] hw_set,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic [NUM_REGS*DATA_W-1:0] pulse_out
);

  localparam int IDX_W = ADDR_W - 2;

  localparam logic [3:0] T_RW    = 4'd0;
  localparam logic [3:0] T_RO    = 4'd1;
  localparam logic [3:0] T_WO    = 4'd2;
  localparam logic [3:0] T_W1C   = 4'd3;
  localparam logic [3:0] T_W1S   = 4'd4;
  localparam logic [3:0] T_W0C   = 4'd5;
  localparam logic [3:0] T_W0S   = 4'd6;
  localparam logic [3:0] T_WONCE = 4'd7;
  localparam logic [3:0] T_RC    = 4'd8;
  localparam logic [3:0] T_RS    = 4'd9;
  localparam logic [3:0] T_W1P   = 4'd10;
  localparam logic [3:0] T_W0P   = 4'd11;
  localparam logic [3:0] T_RSVD  = 4'd12;

  logic [DATA_W-1:0]   r_regs  [NUM_REGS];
  logic [DATA_W-1:0]   r_pulse [NUM_REGS];
  logic [NUM_REGS-1:0] r_lock;
  logic [2:0]          r_waitCnt;

  logic [IDX_W-1:0]    w_index;
  logic                w_inRange;
  logic [3:0]          w_type;
  logic [DATA_W-1:0]   w_selReg;
  logic [DATA_W-1:0]   w_selHw;
  logic                w_selLock;
  logic                w_active;
  logic                w_complete;
  logic                w_err;
  logic [DATA_W-1:0]   w_rdVal;
  logic [NUM_REGS-1:0] w_hit;
  logic [DATA_W-1:0]   w_regNext   [NUM_REGS];
  logic [DATA_W-1:0]   w_pulseNext [NUM_REGS];
  logic [NUM_REGS-1:0] w_lockNext;

  assign w_index    = paddr[ADDR_W-1:2];
  assign w_active   = psel & penable;
  assign pready     = (r_waitCnt == 3'(WAIT_STATES));
  assign w_complete = w_active & pready;

  // Locked WONCE writes share the error path so they leave no side effects.
  assign w_err = (paddr[1:0] != 2'b00) | ~w_inRange | (w_type >= T_RSVD) |
                 (pwrite & (w_type == T_WONCE) & w_selLock);

  assign pslverr = w_complete & w_err;
  assign prdata  = (w_complete & ~pwrite & ~w_err) ? w_rdVal : '0;

  // Select the addressed register's type, stored value, live value and lock.
  always_comb begin
    w_inRange = 1'b0;
    w_type    = T_RW;
    w_selReg  = '0;
    w_selHw   = '0;
    w_selLock = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_index == IDX_W'(k)) begin
        w_inRange = 1'b1;
        w_type    = TYPE_VEC[k*4 +: 4];
        w_selReg  = r_regs[k];
        w_selHw   = hw_rd_val[k*DATA_W +: DATA_W];
        w_selLock = r_lock[k];
      end
    end
  end

  // Read data by type: RO returns the live input, write-only types read 0.
  always_comb begin
    case (w_type)
      T_RO:               w_rdVal = w_selHw;
      T_WO, T_W1P, T_W0P: w_rdVal = '0;
      default:            w_rdVal = w_selReg;
    endcase
  end

  // One-hot strobe of the register taking effect in a good completion cycle.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_hit[k] = w_complete & ~w_err & (w_index == IDX_W'(k));
    end
  end

  // Next register, lock and pulse values; hardware set is applied last so it wins.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_regNext[i]   = r_regs[i];
      w_pulseNext[i] = '0;
      w_lockNext[i]  = r_lock[i];
      if (w_hit[i]) begin
        case (TYPE_VEC[i*4 +: 4])
          T_RW, T_WO: if (pwrite) w_regNext[i] = pwdata;
          T_W1C:      if (pwrite) w_regNext[i] = r_regs[i] & ~pwdata;
          T_W1S:      if (pwrite) w_regNext[i] = r_regs[i] | pwdata;
          T_W0C:      if (pwrite) w_regNext[i] = r_regs[i] & pwdata;
          T_W0S:      if (pwrite) w_regNext[i] = r_regs[i] | ~pwdata;
          T_WONCE: begin
            if (pwrite) begin
              w_regNext[i]  = pwdata;
              w_lockNext[i] = 1'b1;
            end
          end
          T_RC:  w_regNext[i] = pwrite ? pwdata : '0;
          T_RS:  w_regNext[i] = pwrite ? pwdata : '1;
          T_W1P: if (pwrite) w_pulseNext[i] = pwdata;
          T_W0P: if (pwrite) w_pulseNext[i] = ~pwdata;
          default: ;
        endcase
      end
      if ((TYPE_VEC[i*4 +: 4] == T_W1C) || (TYPE_VEC[i*4 +: 4] == T_W0C)) begin
        w_regNext[i] = w_regNext[i] | hw_set[i*DATA_W +: DATA_W];
      end
      if ((TYPE_VEC[i*4 +: 4] == T_W1P) || (TYPE_VEC[i*4 +: 4] == T_W0P)) begin
        w_regNext[i] = '0;
      end
    end
  end

  // Register, pulse and lock state; pulse types never hold a stored value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if ((TYPE_VEC[i*4 +: 4] == T_W1P) || (TYPE_VEC[i*4 +: 4] == T_W0P)) begin
          r_regs[i] <= '0;
        end else begin
          r_regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
        end
        r_pulse[i] <= '0;
      end
      r_lock <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i]  <= w_regNext[i];
        r_pulse[i] <= w_pulseNext[i];
      end
      r_lock <= w_lockNext;
    end
  end

  // Access-phase wait counter; dropping psel abandons the transfer and rearms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt <= 3'd0;
    end else if (!psel || w_complete) begin
      r_waitCnt <= 3'd0;
    end else if (w_active) begin
      r_waitCnt <= r_waitCnt + 3'd1;
    end
  end

  // Flatten the register and pulse arrays onto the wide output buses.
  always_comb begin
    reg_out   = '0;
    pulse_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATA_W +: DATA_W]   = r_regs[i];
      pulse_out[i*DATA_W +: DATA_W] = r_pulse[i];
    end
  end

endmodule

// File: tb/tb_apb_regbank_param.sv
// tb_apb_regbank_param: directed table-driven bench for apb_regbank_param with
// one register of every access type, a reserved slot and two wait states.
module tb_apb_regbank_param;

  localparam int ADDR_W      = 10;
  localparam int DATA_W      = 32;
  localparam int NUM_REGS    = 16;
  localparam int WAIT_STATES = 2;

  // reg15..reg0: RW RW RW RSVD W0P W1P RS RC WONCE W0S W0C W1S W1C WO RO RW
  localparam logic [NUM_REGS*4-1:0] TYPES = {
    4'd0, 4'd0, 4'd0, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8,
    4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};

  localparam logic [NUM_REGS*DATA_W-1:0] RESETS = {
    32'h0, 32'h0, 32'h13131313, 32'h0,
    32'h0, 32'h12345678, 32'h0, 32'hDEADBEEF,
    32'h0, 32'h0, 32'h0000FFFF, 32'h0,
    32'h000000FF, 32'h0, 32'h0, 32'h0};

  logic                       clk;
  logic                       rst_n;
  logic [ADDR_W-1:0]          paddr;
  logic                       psel;
  logic                       penable;
  logic                       pwrite;
  logic [DATA_W-1:0]          pwdata;
  logic [DATA_W-1:0]          prdata;
  logic                       pready;
  logic                       pslverr;
  logic [NUM_REGS*DATA_W-1:0] hw_rd_val;
  logic [NUM_REGS*DATA_W-1:0] hw_set;
  logic [NUM_REGS*DATA_W-1:0] reg_out;
  logic [NUM_REGS*DATA_W-1:0] pulse_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] expData;
    logic              expErr;
  } vec_t;

  vec_t vecs[$];

  apb_regbank_param #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
    .WAIT_STATES(WAIT_STATES), .TYPE_VEC(TYPES), .RESET_VAL(RESETS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .hw_rd_val(hw_rd_val), .hw_set(hw_set),
    .reg_out(reg_out), .pulse_out(pulse_out)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and report any difference.
  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Queue one directed transaction with its expected response.
  task automatic addVec(input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] expData,
                        input logic expErr);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.expData = expData; v.expErr = expErr;
    vecs.push_back(v);
  endtask

  // Run one APB transfer; returns read data, error and access-phase cycle count.
  task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata,
                               output logic [DATA_W-1:0] rdata, output logic err,
                               output int cycles);
    logic done;
    @(posedge clk); #1;
    paddr = addr; pwrite = wr; pwdata = wdata; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    cycles = 0; rdata = '0; err = 1'b0; done = 1'b0;
    while (!done && cycles < 20) begin
      cycles++;
      if (pready) begin
        rdata = prdata;
        err   = pslverr;
        done  = 1'b1;
      end
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    checkOutput("pready_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic              er;
    int                cyc;

    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; hw_set = '0; hw_rd_val = '0;
    hw_rd_val[1*DATA_W +: DATA_W] = 32'hCAFE0001;

    // Reset sweep: every register read back once.
    addVec(0, 10'h000, 0, 32'h00000000, 0);
    addVec(0, 10'h004, 0, 32'hCAFE0001, 0);
    addVec(0, 10'h008, 0, 32'h00000000, 0);
    addVec(0, 10'h00C, 0, 32'h000000FF, 0);
    addVec(0, 10'h010, 0, 32'h00000000, 0);
    addVec(0, 10'h014, 0, 32'h0000FFFF, 0);
    addVec(0, 10'h018, 0, 32'h00000000, 0);
    addVec(0, 10'h01C, 0, 32'h00000000, 0);
    addVec(0, 10'h020, 0, 32'hDEADBEEF, 0);
    addVec(0, 10'h024, 0, 32'h00000000, 0);
    addVec(0, 10'h028, 0, 32'h00000000, 0);
    addVec(0, 10'h02C, 0, 32'h00000000, 0);
    addVec(0, 10'h030, 0, 32'h00000000, 1);
    addVec(0, 10'h034, 0, 32'h13131313, 0);
    addVec(0, 10'h038, 0, 32'h00000000, 0);
    addVec(0, 10'h03C, 0, 32'h00000000, 0);
    // RC cleared and RS set by the sweep reads.
    addVec(0, 10'h020, 0, 32'h00000000, 0);
    addVec(0, 10'h024, 0, 32'hFFFFFFFF, 0);
    // RW, RO, WO.
    addVec(1, 10'h000, 32'h11223344, 0, 0);
    addVec(0, 10'h000, 0, 32'h11223344, 0);
    addVec(1, 10'h004, 32'hFFFFFFFF, 0, 0);
    addVec(0, 10'h004, 0, 32'hCAFE0001, 0);
    addVec(1, 10'h008, 32'hAAAA5555, 0, 0);
    addVec(0, 10'h008, 0, 32'h00000000, 0);
    // W1S, W0C, W0S.
    addVec(1, 10'h010, 32'h0000000F, 0, 0);
    addVec(1, 10'h010, 32'h000000F0, 0, 0);
    addVec(0, 10'h010, 0, 32'h000000FF, 0);
    addVec(1, 10'h014, 32'hFFFF00FF, 0, 0);
    addVec(0, 10'h014, 0, 32'h000000FF, 0);
    addVec(1, 10'h018, 32'hFFFFFF0F, 0, 0);
    addVec(0, 10'h018, 0, 32'h000000F0, 0);
    // WONCE.
    addVec(1, 10'h01C, 32'hA5A5A5A5, 0, 0);
    addVec(1, 10'h01C, 32'h12345678, 0, 1);
    addVec(0, 10'h01C, 0, 32'hA5A5A5A5, 0);
    // RC and RS after writes.
    addVec(1, 10'h020, 32'hDEADBEEF, 0, 0);
    addVec(0, 10'h020, 0, 32'hDEADBEEF, 0);
    addVec(0, 10'h020, 0, 32'h00000000, 0);
    addVec(1, 10'h024, 32'h00000000, 0, 0);
    addVec(0, 10'h024, 0, 32'h00000000, 0);
    addVec(0, 10'h024, 0, 32'hFFFFFFFF, 0);
    // Error accesses: reserved type, misaligned, unmapped.
    addVec(1, 10'h030, 32'h55555555, 0, 1);
    addVec(1, 10'h002, 32'hFFFFFFFF, 0, 1);
    addVec(0, 10'h000, 0, 32'h11223344, 0);
    addVec(0, 10'h002, 0, 32'h00000000, 1);
    addVec(0, 10'h040, 0, 32'h00000000, 1);
    addVec(1, 10'h3FC, 32'h1, 0, 1);
    addVec(1, 10'h034, 32'h00000005, 0, 0);
    addVec(0, 10'h034, 0, 32'h00000005, 0);

    #12 rst_n = 1'b1;
    #1;
    $display("[TB] reset state checks");
    checkOutput("reset_pready", 32'(pready), 32'd0);
    checkOutput("reset_pslverr", 32'(pslverr), 32'd0);
    checkOutput("reset_prdata", prdata, 32'h0);
    checkOutput("reset_pulse_zero", 32'(pulse_out == '0), 32'd1);
    checkOutput("reset_w1p_reg", reg_out[10*DATA_W +: DATA_W], 32'h0);
    checkOutput("reset_reg13", reg_out[13*DATA_W +: DATA_W], 32'h13131313);

    $display("[TB] running %0d table vectors", vecs.size());
    for (int n = 0; n < vecs.size(); n++) begin
      applyStimulus(vecs[n].wr, vecs[n].addr, vecs[n].wdata, rd, er, cyc);
      checkOutput($sformatf("vec%0d_data", n), rd, vecs[n].expData);
      checkOutput($sformatf("vec%0d_err", n), 32'(er), 32'(vecs[n].expErr));
    end

    // WO register stores even though reads return zero.
    checkOutput("wo_stored", reg_out[2*DATA_W +: DATA_W], 32'hAAAA5555);

    // Error access completes on the third access cycle.
    applyStimulus(1'b0, 10'h040, 0, rd, er, cyc);
    checkOutput("wait_cycles", 32'(cyc), 32'd3);
    checkOutput("wait_err", 32'(er), 32'd1);
    checkOutput("wait_data", rd, 32'h0);

    // W1C clear with a simultaneous hardware set on bit 0: set wins.
    hw_set[3*DATA_W] = 1'b1;
    applyStimulus(1'b1, 10'h00C, 32'h0000000F, rd, er, cyc);
    hw_set = '0;
    checkOutput("w1c_regout", reg_out[3*DATA_W +: DATA_W], 32'h000000F1);
    applyStimulus(1'b0, 10'h00C, 0, rd, er, cyc);
    checkOutput("w1c_read", rd, 32'h000000F1);

    // Pulses last exactly one cycle after completion.
    applyStimulus(1'b1, 10'h028, 32'h00000005, rd, er, cyc);
    checkOutput("w1p_pulse", pulse_out[10*DATA_W +: DATA_W], 32'h00000005);
    @(posedge clk); #1;
    checkOutput("w1p_pulse_gone", pulse_out[10*DATA_W +: DATA_W], 32'h0);
    applyStimulus(1'b1, 10'h02C, 32'hFFFFFFFE, rd, er, cyc);
    checkOutput("w0p_pulse", pulse_out[11*DATA_W +: DATA_W], 32'h00000001);
    @(posedge clk); #1;
    checkOutput("w0p_pulse_gone", 32'(pulse_out == '0), 32'd1);
    applyStimulus(1'b0, 10'h028, 0, rd, er, cyc);
    checkOutput("w1p_read", rd, 32'h0);
    applyStimulus(1'b0, 10'h02C, 0, rd, er, cyc);
    checkOutput("w0p_read", rd, 32'h0);

    // Abandoned transfer: psel dropped before pready leaves reg13 untouched.
    @(posedge clk); #1;
    paddr = 10'h034; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    applyStimulus(1'b0, 10'h034, 0, rd, er, cyc);
    checkOutput("abandon_read", rd, 32'h00000005);
    checkOutput("abandon_cycles", 32'(cyc), 32'd3);

    // Reset mid-transfer aborts the write and clears the WONCE lock.
    @(posedge clk); #1;
    paddr = 10'h000; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    psel = 1'b0; penable = 1'b0;
    #4 rst_n = 1'b1;
    applyStimulus(1'b0, 10'h000, 0, rd, er, cyc);
    checkOutput("midreset_read", rd, 32'h0);
    applyStimulus(1'b1, 10'h01C, 32'h00000077, rd, er, cyc);
    checkOutput("relock_err", 32'(er), 32'd0);
    applyStimulus(1'b0, 10'h01C, 0, rd, er, cyc);
    checkOutput("relock_read", rd, 32'h00000077);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_regbank_param.md
# apb_regbank_param

Parametrised APB slave register bank: NUM_REGS registers of DATA_W bits at word-aligned addresses, each with an access type selected per register by a parameter vector. It adds hardware status inputs, pulse outputs, programmable wait states and error signalling for bad accesses. It sits between the APB interconnect and a peripheral core, replacing per-design hand-written register blocks.

## Interface
- ADDR_W, 10, APB address width; must satisfy 2^ADDR_W >= 4*NUM_REGS
- DATA_W, 32, register and bus data width
- NUM_REGS, 16, number of registers (1..64)
- WAIT_STATES, 0, access-phase wait cycles inserted before pready (0..7)
- TYPE_VEC, all 0, NUM_REGS*4 bits, field i = type code of register i
- RESET_VAL, all 0, NUM_REGS*DATA_W bits, field i = reset value of register i

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- paddr  in  ADDR_W  byte address
- psel, penable, pwrite  in  1  APB control
- pwdata  in  DATA_W  write data
- prdata  out  DATA_W  read data, valid only while pready=1 in a read access phase, else 0
- pready  out  1  transfer complete
- pslverr  out  1  error, valid only with pready
- hw_rd_val  in  NUM_REGS*DATA_W  live value returned for RO registers
- hw_set  in  NUM_REGS*DATA_W  per-bit hardware set for W1C/W0C registers
- reg_out  out  NUM_REGS*DATA_W  current stored value of every register
- pulse_out  out  NUM_REGS*DATA_W  one-cycle pulses for W1P/W0P registers

## Operation
- Decode: index = paddr[ADDR_W-1:2]. Error access: paddr[1:0]!=0, index>=NUM_REGS, or reserved type code (12..15). An error access returns pslverr=1 and prdata=0, with no state change.
- Completion cycle: psel & penable & pready. All side effects (writes, read-clear/set, lock, pulses) occur only in this cycle, exactly once per transfer.
- Type codes, write effect / read effect:
  - 0 RW: store pwdata / return value
  - 1 RO: ignored, no error / return hw_rd_val field
  - 2 WO: store / return 0
  - 3 W1C: reg &= ~pwdata / return value
  - 4 W1S: reg |= pwdata / return value
  - 5 W0C: reg &= pwdata / return value
  - 6 W0S: reg |= ~pwdata / return value
  - 7 WONCE: first write stores and sets a lock flag; later writes are ignored with pslverr=1 / return value
  - 8 RC: store / return value, then reg <= 0
  - 9 RS: store / return value, then reg <= all ones
  - 10 W1P: pulse_out field <= pwdata for one cycle; reg stays 0 / return 0
  - 11 W0P: pulse_out field <= ~pwdata for one cycle; reg stays 0 / return 0
- hw_set applies every cycle to types 3 and 5 only: reg |= hw_set. On the same bit in the same cycle as a clearing write, set wins.
- Lock flags clear only on reset.

## Timing
- Wait counter, 3 bits, reset 0. It increments each cycle psel & penable & !pready, and clears on completion or when psel=0.
- pready = (wait_cnt == WAIT_STATES). With WAIT_STATES=0, pready is constant 1 and a transfer takes setup plus 1 access cycle. With WAIT_STATES=N, the access phase lasts N+1 cycles.
- prdata and pslverr are combinational from the pre-update register state in the completion cycle, so RC/RS reads return the old value.
- Register updates and pulse_out become visible on the cycle after completion. pulse_out is all zero on every other cycle; back-to-back pulse writes produce adjacent pulses.
- Reset values:
  - reg_out = RESET_VAL, except types 10/11 reset to 0
  - pulse_out = 0, prdata = 0, pslverr = 0
  - pready = (WAIT_STATES==0)
  - lock flags = 0, wait_cnt = 0
- Reset asserted mid-transfer aborts it with no side effects. The master must restart the transfer.
- A transfer abandoned by dropping psel before pready has no side effects.

## Test plan
- Reset: after rst_n release, read all 16 registers (default types = RW) -> each returns 0; pready=1; pulse_out=0.
- W1C plus hw_set: reg3 type 3 holds 0x0000_00FF; write 0x0F while hw_set bit0=1 in the same cycle -> reg reads 0x0000_00F1.
- WONCE: write 0xA5A5_A5A5 then 0x1234_5678 to a type-7 register -> second write has pslverr=1; read returns 0xA5A5_A5A5.
- RC/RS: RC register holds 0xDEAD_BEEF -> first read returns 0xDEAD_BEEF, second returns 0. RS register holding 0 -> first read returns 0, second returns 0xFFFF_FFFF.
- Pulses: write 0x0000_0005 to W1P and 0xFFFF_FFFE to W0P -> each pulse_out field equals 0x5 and 0x1 respectively for exactly one cycle; reads of both return 0.
- Errors and waits: with WAIT_STATES=2, access paddr=0x002 and paddr=0x040 (NUM_REGS=16) -> pready rises on the 3rd access cycle with pslverr=1, prdata=0, and no register changes.
